// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the system-bus arbiter (FSM state codes, sizing helpers).
// Latency: none (declarations only).
// Backpressure: n/a.
package bus_arbiter_pkg;

  // Arbiter FSM state codes.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int MASTER_NUM_DEF  = 4;    // core + UART loader + JTAG debug + spare
  localparam int TIMEOUT_CYC_DEF = 255;  // watchdog limit, legal range 1..255
  localparam int WDOG_W          = 8;    // wide enough for the largest legal limit

  // Width of a master index; a single master still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational request picker: first set request found searching upward (with wrap) from ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a; the caller decides when the pick is consumed.
//
// Ports:
//   req   - request vector
//   ptr   - search start index (in search order)
//   pick  - one-hot selected request (0 when none)
//   idx   - index of the selected request (0 when none)
//   found - at least one request is set
// HIGH_FIRST=1 reverses the search order so that, with ptr=0, the highest index wins.
module arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N          = 4,
  parameter bit HIGH_FIRST = 1'b0,
  localparam int IW        = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0]  req_ord;
  logic [N-1:0]  pick_ord;
  logic [IW-1:0] idx_ord;
  logic [IW-1:0] pos;

  // Map requests into search order.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ord[i] = HIGH_FIRST ? req[N-1-i] : req[i];
    end
  end

  // Rotating first-one search starting at ptr.
  always_comb begin
    pick_ord = '0;
    idx_ord  = '0;
    found    = 1'b0;
    pos      = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!found && req_ord[pos]) begin
        found         = 1'b1;
        pick_ord[pos] = 1'b1;
        idx_ord       = pos;
      end
    end
  end

  // Map the result back to request numbering.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pick[i] = HIGH_FIRST ? pick_ord[N-1-i] : pick_ord[i];
    end
    if (!found) begin
      idx = '0;
    end else if (HIGH_FIRST) begin
      idx = IW'(N - 1) - idx_ord;
    end else begin
      idx = idx_ord;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// System-bus arbiter: grants one master at a time and holds the grant until slave ack, abort or watchdog expiry.
// Latency: grant registered 1 cycle after request; always one idle bubble cycle between grants.
// Backpressure: masters hold req_i until ack; hold_flag_o stalls the core pipeline while it is kept off the bus.
//
// Ports:
//   clk, rst     - clock; synchronous active-high reset
//   req_i        - per-master level request (index 0 = core)
//   s_ack_i      - slave completion pulse for the current transaction
//   gnt_o        - registered one-hot grant
//   owner_o      - index of the granted master (0 when idle)
//   busy_o       - bus owned
//   hold_flag_o  - core requests but does not own the bus, or another master owns it
//   timeout_o    - one-cycle pulse when the watchdog forces a release
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (highest index wins).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MASTER_NUM  = MASTER_NUM_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int IW         = idx_width(MASTER_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] req_i,
  input  logic                  s_ack_i,
  output logic [MASTER_NUM-1:0] gnt_o,
  output logic [IW-1:0]         owner_o,
  output logic                  busy_o,
  output logic                  hold_flag_o,
  output logic                  timeout_o
);

  // Watchdog value seen on the last permitted BUSY cycle.
  localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [MASTER_NUM-1:0] gnt_q;
  logic [IW-1:0]         owner_q;
  logic                  timeout_q;
  logic [WDOG_W-1:0]     wdog_q;

  logic [MASTER_NUM-1:0] pick;
  logic [IW-1:0]         pick_idx;
  logic                  pick_vld;
  logic [IW-1:0]         ptr;

  logic in_busy;
  logic owner_req;
  logic ack_done;
  logic abort;
  logic expire;
  logic release_ok;

  assign in_busy   = (state_q == ARB_BUSY);
  assign owner_req = |(req_i & gnt_q);
  // Ack wins over a simultaneous request drop or watchdog expiry; an abort suppresses the timeout.
  assign ack_done   = in_busy && s_ack_i;
  assign abort      = in_busy && !s_ack_i && !owner_req;
  assign expire     = in_busy && !s_ack_i && owner_req && (wdog_q == WD_LAST);
  assign release_ok = ack_done || abort;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr_q;

  // Next search starts just above the last owner; a timed-out master keeps its turn position.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (release_ok) begin
      rr_ptr_q <= (owner_q == IW'(MASTER_NUM - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  assign ptr = rr_ptr_q;

  arb_pick #(.N(MASTER_NUM), .HIGH_FIRST(1'b0)) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .found (pick_vld)
  );
`else
  // Fixed priority: reversed search order from a constant zero start.
  assign ptr = '0;

  arb_pick #(.N(MASTER_NUM), .HIGH_FIRST(1'b1)) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .found (pick_vld)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Ack in IDLE is ignored; BUSY never re-arbitrates.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_vld) state_d = ARB_BUSY;
      ARB_BUSY: if (release_ok || expire) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Grant/owner, watchdog and timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      timeout_q <= expire;
      if (!in_busy && pick_vld) begin
        gnt_q   <= pick;
        owner_q <= pick_idx;
      end else if (state_d == ARB_IDLE) begin
        gnt_q   <= '0;
        owner_q <= '0;
      end
      // Zero on every entry to BUSY; counts the BUSY cycles already spent.
      wdog_q <= (in_busy && state_d == ARB_BUSY) ? wdog_q + 1'b1 : '0;
    end
  end

  // Outputs.
  always_comb begin
    gnt_o       = gnt_q;
    owner_o     = owner_q;
    busy_o      = in_busy;
    timeout_o   = timeout_q;
    hold_flag_o = (req_i[0] && !gnt_q[0]) || (in_busy && (owner_q != '0));
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table for single-cycle behaviour plus sequences for watchdog, reset and ordering.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic       s_ack_i;
  logic [3:0] gnt_o;
  logic [1:0] owner_o;
  logic       busy_o;
  logic       hold_flag_o;
  logic       timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(.MASTER_NUM(4), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .s_ack_i     (s_ack_i),
    .gnt_o       (gnt_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .hold_flag_o (hold_flag_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       hold;
    logic       tmo;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  logic [3:0] ord_exp[5];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                           input logic eb, input logic eh, input logic et);
    check({tag, " gnt"},     8'(gnt_o),       8'(eg));
    check({tag, " owner"},   8'(owner_o),     8'(eo));
    check({tag, " busy"},    8'(busy_o),      8'(eb));
    check({tag, " hold"},    8'(hold_flag_o), 8'(eh));
    check({tag, " timeout"}, 8'(timeout_o),   8'(et));
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic a);
    rst     = r;
    req_i   = q;
    s_ack_i = a;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    drive(1'b1, 4'b0000, 1'b0);
    step();
    drive(1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    drive(1'b1, 4'b0000, 1'b0);

    //            rst   req      ack   gnt      own   busy  hold  tmo
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}; // reset state
    vecs[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0}; // core granted next cycle
    vecs[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}; // ack -> idle bubble
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1011, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0}; // highest index wins
    vecs[7]  = '{1'b0, 4'b1011, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b1011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0}; // no preemption
    vecs[11] = '{1'b0, 4'b1101, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}; // owner drops -> abort
    vecs[12] = '{1'b0, 4'b1101, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}; // ack + drop together
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}; // ack in idle ignored
    vecs[15] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};

`ifdef ARB_ROUND_ROBIN_EN
    ord_exp[0] = 4'b0001; ord_exp[1] = 4'b0010; ord_exp[2] = 4'b0100;
    ord_exp[3] = 4'b1000; ord_exp[4] = 4'b0001;
`else
    for (int i = 0; i < 5; i++) ord_exp[i] = 4'b1000;
`endif

    @(negedge clk);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed-priority vector table.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].ack);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner,
                vecs[i].busy, vecs[i].hold, vecs[i].tmo);
    end
`endif

    // Watchdog expiry: master 2 granted for exactly 8 cycles, then forced release.
    reset_dut();
    drive(1'b0, 4'b0100, 1'b0);
    step();
    check_all("wd_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("wd_hold%0d gnt", i), 8'(gnt_o), 8'h04);
      check($sformatf("wd_hold%0d timeout", i), 8'(timeout_o), 8'h00);
    end
    step();
    check_all("wd_expire", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    check_all("wd_regrant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);

    // Ack on the exact expiry cycle is a normal completion.
    for (int i = 0; i < 7; i++) step();
    check("wd_prelast gnt", 8'(gnt_o), 8'h04);
    drive(1'b0, 4'b0100, 1'b1);
    step();
    check_all("wd_ack_last", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    step();
    check("wd_ack_last_after timeout", 8'(timeout_o), 8'h00);

    // Reset mid-transaction, then a clean grant afterwards.
    reset_dut();
    drive(1'b0, 4'b0010, 1'b0);
    step();
    check_all("rst_grant", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'b0010, 1'b0);
    step();
    check_all("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0001, 1'b0);
    step();
    check_all("rst_after", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    // All masters requesting, ack every third cycle.
    reset_dut();
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, 4'b1111, 1'b0);
      step();
      check($sformatf("order%0d gnt", g), 8'(gnt_o), 8'(ord_exp[g]));
      step();
      drive(1'b0, 4'b1111, 1'b1);
      step();
      check($sformatf("order%0d release", g), 8'(gnt_o), 8'h00);
    end
    drive(1'b0, 4'b0000, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
